// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment readback monitor: segment width,
// the active-low hex glyph table, the blank pattern and the capture FSM states.
package sevenseg_pkg;

    localparam int SEG_W = 7;

    // Active-low glyphs, bit0=a ... bit6=g, indexed by the hex value shown.
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern into a hex
// nibble. Patterns that are neither a table glyph nor blank are illegal.
module seg_to_hex
    import sevenseg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_n,
    output logic [3:0]       nibble,
    output logic             is_hex,
    output logic             is_blank
);

    // Search the glyph table; entries are unique so at most one matches.
    always_comb begin
        nibble = 4'd0;
        is_hex = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_TABLE[i]) begin
                nibble = 4'(i);
                is_hex = 1'b1;
            end
        end
    end

    assign is_blank = (seg_n == SEG_BLANK);

endmodule

// File: rtl/sevenseg_capture.sv
// Readback monitor for a multiplexed active-low seven-segment bus. A digit
// pattern must stay unchanged for STABLE_CYCLES samples before it is committed
// into the per-digit registers; illegal glyphs are flagged and counted.
//
// Handshake: none. commit_pulse, frame_done and bad_pattern are single-cycle
// strobes with no back-pressure; digits/digit_valid/err_count are levels that
// change only on the edge that raises commit_pulse (or on clear_err).
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SEG_W-1:0]        seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    clear_err,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    commit_pulse,
    output logic                    frame_done,
    output logic                    bad_pattern,
    output logic [ERR_W-1:0]        err_count,
    output logic [1:0]              state_dbg
);

    localparam int SW = NUM_DIGITS + SEG_W;

    logic [SW-1:0]         sample_q;
    logic [SW-1:0]         sample_d;
    logic                  change;
    logic [NUM_DIGITS-1:0] in_sel;
    logic [NUM_DIGITS-1:0] q_sel;
    logic [3:0]            zero_cnt;
    logic                  in_legal;
    cap_state_t            state_q;
    logic [7:0]            cnt_q;
    logic [NUM_DIGITS-1:0] seen_q;
    logic [NUM_DIGITS-1:0] seen_next;
    logic [3:0]            dec_nibble;
    logic                  dec_hex;
    logic                  dec_blank;
    logic                  commit_now;
    logic                  bad_now;

    // The incoming bus is compared against sample_q so that a change is
    // recognised on the same edge that registers it; this makes a value first
    // sampled at edge k commit exactly at edge k+STABLE_CYCLES.
    assign sample_d = {an_n, seg_n};
    assign change   = (sample_d != sample_q);
    assign in_sel   = ~an_n;
    assign q_sel    = ~sample_q[SW-1:SEG_W];

    // Input stage: one register on the whole bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sample_q <= '1;
        else          sample_q <= sample_d;
    end

    // A digit is selected only when exactly one anode line is low.
    always_comb begin
        zero_cnt = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_cnt = zero_cnt + 4'(in_sel[i]);
        end
        in_legal = (zero_cnt == 4'd1);
    end

    seg_to_hex u_dec (
        .seg_n    (sample_q[SEG_W-1:0]),
        .nibble   (dec_nibble),
        .is_hex   (dec_hex),
        .is_blank (dec_blank)
    );

    assign commit_now = (state_q == SETTLE) && (cnt_q == 8'(STABLE_CYCLES));
    assign bad_now    = commit_now && !dec_hex && !dec_blank;
    assign seen_next  = seen_q | q_sel;
    assign state_dbg  = state_q;

    // Capture FSM with registered digit, mask and strobe outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            digits       <= '0;
            digit_valid  <= '0;
            seen_q       <= '0;
            commit_pulse <= 1'b0;
            frame_done   <= 1'b0;
            bad_pattern  <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            frame_done   <= 1'b0;
            bad_pattern  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_legal) begin
                        state_q <= SETTLE;
                        cnt_q   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (commit_now) begin
                        commit_pulse <= 1'b1;
                        bad_pattern  <= bad_now;
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (q_sel[i]) begin
                                if (dec_hex) begin
                                    digits[4*i +: 4] <= dec_nibble;
                                    digit_valid[i]   <= 1'b1;
                                end else begin
                                    digit_valid[i]   <= 1'b0;
                                end
                            end
                        end
                        // The completing digit starts the next frame empty.
                        if (&seen_next) begin
                            frame_done <= 1'b1;
                            seen_q     <= '0;
                        end else begin
                            seen_q     <= seen_next;
                        end
                    end
                    if (change) begin
                        state_q <= in_legal ? SETTLE : IDLE;
                        cnt_q   <= 8'd1;
                    end else if (commit_now) begin
                        state_q <= HELD;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                    end
                end
                HELD: begin
                    if (change) begin
                        state_q <= in_legal ? SETTLE : IDLE;
                        cnt_q   <= 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating illegal-pattern counter; a clear coinciding with a bad
    // commit leaves that commit counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (clear_err) begin
            err_count <= bad_now ? ERR_W'(1) : '0;
        end else if (bad_now && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture with 4 digits and a 4-sample window.
module tb_sevenseg_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        clear_err;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        commit_pulse;
    logic        frame_done;
    logic        bad_pattern;
    logic [7:0]  err_count;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_commit = 0;
    int n_frame  = 0;
    int n_bad    = 0;
    int c0, f0, b0;

    logic [6:0] scan_seg [4];

    sevenseg_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4),
        .ERR_W         (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .clear_err    (clear_err),
        .digits       (digits),
        .digit_valid  (digit_valid),
        .commit_pulse (commit_pulse),
        .frame_done   (frame_done),
        .bad_pattern  (bad_pattern),
        .err_count    (err_count),
        .state_dbg    (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 ns after each edge and tallying strobes.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (commit_pulse) n_commit++;
            if (frame_done)   n_frame++;
            if (bad_pattern)  n_bad++;
        end
    endtask

    initial begin
        scan_seg[0] = 7'b0001000;  // A
        scan_seg[1] = 7'b0000011;  // b
        scan_seg[2] = 7'b1000110;  // C
        scan_seg[3] = 7'b0100001;  // d

        reset_n   = 1'b0;
        an_n      = 4'hF;
        seg_n     = 7'h7F;
        clear_err = 1'b0;
        #12;
        check("rst_digits", digits, 16'h0);
        check("rst_valid", digit_valid, 4'h0);
        check("rst_err", err_count, 8'h0);
        check("rst_state", state_dbg, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle bus: nothing happens.
        step(20);
        check("idle_pulses", n_commit + n_frame + n_bad, 0);
        check("idle_digits", digits, 16'h0);
        check("idle_valid", digit_valid, 4'h0);

        // Digit 0 shows 3.
        c0 = n_commit;
        an_n  = 4'b1110;
        seg_n = 7'b0110000;
        step(4);
        check("d0_no_early", n_commit - c0, 0);
        step(1);
        check("d0_pulse", commit_pulse, 1'b1);
        check("d0_value", digits[3:0], 4'h3);
        check("d0_valid", digit_valid, 4'b0001);
        check("d0_no_frame", frame_done, 1'b0);
        step(10);
        check("d0_single_pulse", n_commit - c0, 1);
        check("d0_held_state", state_dbg, 2'd2);

        // Glitching pattern every 2 cycles never commits.
        c0 = n_commit;
        for (int j = 0; j < 8; j++) begin
            seg_n = (j % 2 == 0) ? 7'b0100100 : 7'b0110000;
            step(2);
        end
        check("glitch_no_commit", n_commit - c0, 0);
        check("glitch_keep", digits[3:0], 4'h3);
        seg_n = 7'b0100100;
        step(4);
        check("glitch_no_early", n_commit - c0, 0);
        step(1);
        check("glitch_pulse", commit_pulse, 1'b1);
        check("glitch_value", digits[3:0], 4'h2);

        // Two full scans of A,b,C,d.
        for (int s = 0; s < 2; s++) begin
            c0 = n_commit;
            f0 = n_frame;
            for (int d = 0; d < 4; d++) begin
                an_n  = ~(4'b0001 << d);
                seg_n = scan_seg[d];
                step(6);
            end
            check("scan_digits", digits, 16'hDCBA);
            check("scan_valid", digit_valid, 4'hF);
            check("scan_commits", n_commit - c0, 4);
            check("scan_frame", n_frame - f0, 1);
        end

        // Blank on digit 3 keeps the nibble but drops valid.
        b0 = n_bad;
        seg_n = 7'h7F;
        step(5);
        check("blank_pulse", commit_pulse, 1'b1);
        check("blank_valid", digit_valid, 4'b0111);
        check("blank_keep", digits[15:12], 4'hD);
        check("blank_not_bad", n_bad - b0, 0);

        // Illegal glyph on digit 2.
        an_n  = 4'b1011;
        seg_n = 7'b1010101;
        step(5);
        check("bad_pulse", bad_pattern, 1'b1);
        check("bad_commit", commit_pulse, 1'b1);
        check("bad_err1", err_count, 8'd1);
        check("bad_valid", digit_valid, 4'b0011);
        check("bad_keep", digits[11:8], 4'hC);

        // 300 more illegal commits saturate the counter.
        b0 = n_bad;
        for (int i = 0; i < 300; i++) begin
            an_n = (i % 2 == 0) ? 4'b1101 : 4'b1011;
            step(4);
        end
        step(1);
        check("sat_bad_count", n_bad - b0, 300);
        check("sat_err", err_count, 8'hFF);
        check("sat_valid", digit_valid, 4'b0001);

        // Clear on the same edge as a bad commit leaves one.
        an_n = 4'b1101;
        step(4);
        clear_err = 1'b1;
        step(1);
        check("clr_bad_same", bad_pattern, 1'b1);
        check("clr_err_one", err_count, 8'd1);
        step(1);
        check("clr_err_zero", err_count, 8'd0);
        clear_err = 1'b0;

        // Two anodes low: never a digit.
        c0 = n_commit;
        an_n  = 4'b1100;
        seg_n = 7'b0110000;
        step(10);
        check("two_an_no_commit", n_commit - c0, 0);
        check("two_an_idle", state_dbg, 2'd0);

        // One more bad commit so reset has something to clear.
        an_n  = 4'b0111;
        seg_n = 7'b1010101;
        step(5);
        check("pre_rst_err", err_count, 8'd1);

        // Asynchronous reset while settling.
        an_n  = 4'b1110;
        seg_n = 7'b1000000;
        step(2);
        check("mid_settle", state_dbg, 2'd1);
        reset_n = 1'b0;
        #1;
        check("arst_digits", digits, 16'h0);
        check("arst_valid", digit_valid, 4'h0);
        check("arst_err", err_count, 8'h0);
        check("arst_state", state_dbg, 2'd0);
        an_n  = 4'hF;
        seg_n = 7'h7F;
        step(2);
        reset_n = 1'b1;
        c0 = n_commit;
        step(10);
        check("post_rst_quiet", n_commit - c0, 0);
        check("post_rst_digits", digits, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
